// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter and byte sequencer for the data-segment memory port.
// Two requesters share one byte-wide port; 16-bit accesses become two little-endian byte cycles.
//
//   state | meaning
//   IDLE  | waiting for a request; arbitration and range check happen here
//   BYTE0 | low byte (addr) on the memory port
//   BYTE1 | high byte (addr+1) on the memory port, word accesses only
//   DONE  | one-cycle completion pulse with rdata/err to the granted requester
module data_mem_arbiter #(
    parameter int WIDTH   = 16,
    parameter int RAMSIZE = 16,
    parameter int NBANKS  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             r0_req,
    input  logic             r0_we,
    input  logic             r0_word,
    input  logic [WIDTH-1:0] r0_addr,
    input  logic [WIDTH-1:0] r0_wdata,
    output logic             r0_done,
    input  logic             r1_req,
    input  logic             r1_we,
    input  logic             r1_word,
    input  logic [WIDTH-1:0] r1_addr,
    input  logic [WIDTH-1:0] r1_wdata,
    output logic             r1_done,
    output logic [WIDTH-1:0] rdata,
    output logic             err,
    output logic             busy,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_a,
    output logic [WIDTH-1:0] mem_wd,
    input  logic [WIDTH-1:0] mem_rd
);

    // One extra bit so an address near the top of the space cannot wrap past the limit.
    localparam logic [WIDTH:0] LIM = (WIDTH+1)'(RAMSIZE * NBANKS);

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_t;

    state_t           state;
    logic             rr_last;
    logic             id_q;
    logic             we_q;
    logic             word_q;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] wdata_q;
    logic [7:0]       rd_lo;

    logic             gnt_valid;
    logic             gnt_id;
    logic             sel_we;
    logic             sel_word;
    logic [WIDTH-1:0] sel_addr;
    logic [WIDTH-1:0] sel_wdata;
    logic             oor;

    logic unused_rd_hi;
    assign unused_rd_hi = ^mem_rd[WIDTH-1:8];

    always_comb begin
        gnt_valid = r0_req | r1_req;
        if (r0_req && r1_req)
            gnt_id = ~rr_last;
        else
            gnt_id = r1_req;
        sel_we    = gnt_id ? r1_we    : r0_we;
        sel_word  = gnt_id ? r1_word  : r0_word;
        sel_addr  = gnt_id ? r1_addr  : r0_addr;
        sel_wdata = gnt_id ? r1_wdata : r0_wdata;
        oor = ({1'b0, sel_addr} >= LIM) ||
              (sel_word && ({1'b0, sel_addr} >= (LIM - 1'b1)));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_last <= 1'b1;
            id_q    <= 1'b0;
            we_q    <= 1'b0;
            word_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_lo   <= '0;
            r0_done <= 1'b0;
            r1_done <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            mem_we  <= 1'b0;
            mem_a   <= '0;
            mem_wd  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        id_q    <= gnt_id;
                        we_q    <= sel_we;
                        word_q  <= sel_word;
                        addr_q  <= sel_addr;
                        wdata_q <= sel_wdata;
                        rr_last <= gnt_id;
                        busy    <= 1'b1;
                        if (oor) begin
                            state   <= DONE;
                            err     <= 1'b1;
                            rdata   <= '0;
                            r0_done <= ~gnt_id;
                            r1_done <= gnt_id;
                        end else begin
                            state  <= BYTE0;
                            mem_a  <= sel_addr;
                            mem_we <= sel_we;
                            mem_wd <= WIDTH'(sel_wdata[7:0]);
                        end
                    end
                end
                BYTE0: begin
                    rd_lo <= mem_rd[7:0];
                    if (word_q) begin
                        state  <= BYTE1;
                        mem_a  <= addr_q + WIDTH'(1);
                        mem_wd <= WIDTH'(wdata_q[15:8]);
                    end else begin
                        state   <= DONE;
                        mem_we  <= 1'b0;
                        mem_a   <= '0;
                        mem_wd  <= '0;
                        rdata   <= we_q ? '0 : WIDTH'(mem_rd[7:0]);
                        r0_done <= ~id_q;
                        r1_done <= id_q;
                    end
                end
                BYTE1: begin
                    state   <= DONE;
                    mem_we  <= 1'b0;
                    mem_a   <= '0;
                    mem_wd  <= '0;
                    rdata   <= we_q ? '0 : WIDTH'({mem_rd[7:0], rd_lo});
                    r0_done <= ~id_q;
                    r1_done <= id_q;
                end
                DONE: begin
                    state   <= IDLE;
                    r0_done <= 1'b0;
                    r1_done <= 1'b0;
                    rdata   <= '0;
                    err     <= 1'b0;
                    busy    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: byte memory model on the port plus a reference byte array
// updated from the access rules; directed scenarios followed by randomized accesses.
module tb_data_mem_arbiter;

    localparam int LIMIT = 48;

    logic        clk = 1'b0;
    logic        reset;
    logic        r0_req, r0_we, r0_word, r0_done;
    logic [15:0] r0_addr, r0_wdata;
    logic        r1_req, r1_we, r1_word, r1_done;
    logic [15:0] r1_addr, r1_wdata;
    logic [15:0] rdata;
    logic        err, busy, mem_we;
    logic [15:0] mem_a, mem_wd, mem_rd;

    logic [7:0] phys [0:65535];
    logic [7:0] refm [0:LIMIT-1];

    int vectors = 0;
    int miscompares = 0;

    data_mem_arbiter #(.WIDTH(16), .RAMSIZE(16), .NBANKS(3)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_word(r0_word), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_done(r0_done),
        .r1_req(r1_req), .r1_we(r1_we), .r1_word(r1_word), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_done(r1_done),
        .rdata(rdata), .err(err), .busy(busy),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // The memory shares the system reset, so no write lands on an edge where reset is high.
    assign mem_rd = {8'h00, phys[mem_a]};
    always @(posedge clk) if (mem_we && !reset) phys[mem_a] <= mem_wd[7:0];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id, input logic req, input logic we, input logic word,
                         input logic [15:0] a, input logic [15:0] d);
        if (id == 0) begin
            r0_req = req; r0_we = we; r0_word = word; r0_addr = a; r0_wdata = d;
        end else begin
            r1_req = req; r1_we = we; r1_word = word; r1_addr = a; r1_wdata = d;
        end
    endtask

    // Runs one handshake from IDLE; lat = cycles from sampling edge to done (-1 on timeout).
    task automatic do_access(input int id, input logic we, input logic word,
                             input logic [15:0] a, input logic [15:0] d,
                             output int lat, output logic [15:0] rd, output logic er,
                             output logic other, output logic saw_we, output logic b0_we,
                             output logic [15:0] b0_a, output logic [15:0] b0_wd);
        logic own;
        lat = -1; rd = '0; er = 1'b0; other = 1'b0; saw_we = 1'b0;
        b0_we = 1'b0; b0_a = '0; b0_wd = '0;
        drive(id, 1'b1, we, word, a, d);
        for (int c = 1; c <= 10; c++) begin
            tick;
            if (mem_we) saw_we = 1'b1;
            if (c == 1) begin b0_we = mem_we; b0_a = mem_a; b0_wd = mem_wd; end
            own = (id == 0) ? r0_done : r1_done;
            if ((id == 0) ? r1_done : r0_done) other = 1'b1;
            if (own) begin lat = c; rd = rdata; er = err; break; end
        end
        drive(id, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick; tick;
        reset = 1'b0;
        vectors++;
        if ({r0_done, r1_done, err, busy, mem_we} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b expected 00000", {r0_done, r1_done, err, busy, mem_we});
        end
        vectors++;
        if ({rdata, mem_a, mem_wd} !== 48'h0) begin
            miscompares++;
            $display("FAIL reset_buses: got %h expected 0", {rdata, mem_a, mem_wd});
        end
    endtask

    task automatic test_byte_write;
        int lat; logic [15:0] rd, b0a, b0wd; logic er, oth, sw, b0we;
        do_access(0, 1'b1, 1'b0, 16'h0005, 16'h00A7, lat, rd, er, oth, sw, b0we, b0a, b0wd);
        refm[5] = 8'hA7;
        vectors++;
        if ({b0we, b0a, b0wd} !== {1'b1, 16'h0005, 16'h00A7}) begin
            miscompares++;
            $display("FAIL bw_byte0: got we=%b a=%h wd=%h expected we=1 a=0005 wd=00a7", b0we, b0a, b0wd);
        end
        vectors++;
        if (lat !== 2 || er !== 1'b0 || oth !== 1'b0 || rd !== 16'h0) begin
            miscompares++;
            $display("FAIL bw_done: got lat=%0d err=%b other=%b rdata=%h expected 2 0 0 0000", lat, er, oth, rd);
        end
        vectors++;
        if (phys[5] !== 8'hA7) begin
            miscompares++;
            $display("FAIL bw_mem: got %h expected a7", phys[5]);
        end
    endtask

    task automatic test_word_rw;
        int lat; logic [15:0] rd, b0a, b0wd; logic er, oth, sw, b0we;
        do_access(1, 1'b1, 1'b1, 16'h000F, 16'hBEEF, lat, rd, er, oth, sw, b0we, b0a, b0wd);
        refm[15] = 8'hEF; refm[16] = 8'hBE;
        vectors++;
        if (lat !== 3 || er !== 1'b0 || oth !== 1'b0) begin
            miscompares++;
            $display("FAIL ww_done: got lat=%0d err=%b other=%b expected 3 0 0", lat, er, oth);
        end
        vectors++;
        if ({phys[16], phys[15]} !== 16'hBEEF) begin
            miscompares++;
            $display("FAIL ww_mem: got %h expected beef", {phys[16], phys[15]});
        end
        do_access(1, 1'b0, 1'b1, 16'h000F, 16'h0000, lat, rd, er, oth, sw, b0we, b0a, b0wd);
        vectors++;
        if (lat !== 3 || rd !== 16'hBEEF || er !== 1'b0 || oth !== 1'b0 || sw !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_done: got lat=%0d rdata=%h err=%b other=%b we=%b expected 3 beef 0 0 0",
                     lat, rd, er, oth, sw);
        end
    endtask

    task automatic test_fairness;
        int order[$];
        int both = 0;
        int bad_rd = 0;
        reset = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0);
        tick; tick;
        reset = 1'b0;
        for (int c = 0; c < 40; c++) begin
            tick;
            if (r0_done && r1_done) both++;
            if (r0_done) begin
                order.push_back(0);
                if (rdata !== {8'h00, refm[3]}) bad_rd++;
            end else if (r1_done) begin
                order.push_back(1);
                if (rdata !== {8'h00, refm[7]}) bad_rd++;
            end
        end
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) tick;
        vectors++;
        if (both !== 0 || bad_rd !== 0) begin
            miscompares++;
            $display("FAIL rr_done: got both=%0d bad_rdata=%0d expected 0 0", both, bad_rd);
        end
        vectors++;
        if (order.size() < 12) begin
            miscompares++;
            $display("FAIL rr_count: got %0d grants expected at least 12", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            vectors++;
            if (order[i] !== (i % 2)) begin
                miscompares++;
                $display("FAIL rr_order[%0d]: got r%0d expected r%0d", i, order[i], i % 2);
            end
        end
    endtask

    task automatic test_range;
        int lat; logic [15:0] rd, b0a, b0wd; logic er, oth, sw, b0we;
        do_access(0, 1'b0, 1'b0, 16'h0030, 16'h0, lat, rd, er, oth, sw, b0we, b0a, b0wd);
        vectors++;
        if (lat !== 1 || er !== 1'b1 || rd !== 16'h0 || sw !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_byte48: got lat=%0d err=%b rdata=%h we=%b expected 1 1 0000 0", lat, er, rd, sw);
        end
        do_access(0, 1'b0, 1'b1, 16'h002F, 16'h0, lat, rd, er, oth, sw, b0we, b0a, b0wd);
        vectors++;
        if (lat !== 1 || er !== 1'b1 || rd !== 16'h0 || sw !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_word47: got lat=%0d err=%b rdata=%h we=%b expected 1 1 0000 0", lat, er, rd, sw);
        end
        do_access(0, 1'b0, 1'b0, 16'h002F, 16'h0, lat, rd, er, oth, sw, b0we, b0a, b0wd);
        vectors++;
        if (lat !== 2 || er !== 1'b0 || rd !== {8'h00, refm[47]}) begin
            miscompares++;
            $display("FAIL inr_byte47: got lat=%0d err=%b rdata=%h expected 2 0 %h", lat, er, rd, {8'h00, refm[47]});
        end
        do_access(1, 1'b1, 1'b1, 16'hFFFF, 16'h5555, lat, rd, er, oth, sw, b0we, b0a, b0wd);
        vectors++;
        if (lat !== 1 || er !== 1'b1 || sw !== 1'b0) begin
            miscompares++;
            $display("FAIL oor_wordffff: got lat=%0d err=%b we=%b expected 1 1 0", lat, er, sw);
        end
        do_access(0, 1'b0, 1'b1, 16'h002E, 16'h0, lat, rd, er, oth, sw, b0we, b0a, b0wd);
        vectors++;
        if (lat !== 3 || er !== 1'b0 || rd !== {refm[47], refm[46]}) begin
            miscompares++;
            $display("FAIL inr_word46: got lat=%0d err=%b rdata=%h expected 3 0 %h", lat, er, rd, {refm[47], refm[46]});
        end
    endtask

    task automatic test_reset_abort;
        int stray = 0;
        drive(0, 1'b1, 1'b1, 1'b1, 16'h0010, 16'h1234);
        tick; tick;
        vectors++;
        if ({busy, mem_we, mem_a, mem_wd} !== {1'b1, 1'b1, 16'h0011, 16'h0012}) begin
            miscompares++;
            $display("FAIL abort_byte1: got busy=%b we=%b a=%h wd=%h expected 1 1 0011 0012", busy, mem_we, mem_a, mem_wd);
        end
        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        tick;
        reset = 1'b0;
        vectors++;
        if ({r0_done, r1_done, err, busy, mem_we, rdata, mem_a, mem_wd} !== 53'h0) begin
            miscompares++;
            $display("FAIL abort_outputs: got %h expected 0", {r0_done, r1_done, err, busy, mem_we, rdata, mem_a, mem_wd});
        end
        refm[16] = 8'h34;
        vectors++;
        if (phys[16] !== 8'h34 || phys[17] !== refm[17]) begin
            miscompares++;
            $display("FAIL abort_mem: got %h %h expected 34 %h", phys[16], phys[17], refm[17]);
        end
        repeat (4) begin
            tick;
            if (r0_done || r1_done || mem_we || busy) stray++;
        end
        vectors++;
        if (stray !== 0) begin
            miscompares++;
            $display("FAIL abort_retry: got %0d active cycles expected 0", stray);
        end
    endtask

    task automatic test_hold_repeat;
        int t1 = -1;
        int t2 = -1;
        int extra = 0;
        drive(1, 1'b1, 1'b1, 1'b0, 16'h0008, 16'h005A);
        for (int c = 1; c <= 20; c++) begin
            tick;
            if (r1_done) begin
                if (t1 < 0) t1 = c;
                else begin t2 = c; break; end
            end
        end
        drive(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (5) begin
            tick;
            if (r0_done || r1_done) extra++;
        end
        refm[8] = 8'h5A;
        vectors++;
        if (t1 !== 2 || (t2 - t1) !== 3 || t2 < 0) begin
            miscompares++;
            $display("FAIL hold_repeat: got first=%0d second=%0d expected 2 5", t1, t2);
        end
        vectors++;
        if (extra !== 0 || phys[8] !== 8'h5A) begin
            miscompares++;
            $display("FAIL hold_after: got extra=%0d mem=%h expected 0 5a", extra, phys[8]);
        end
    endtask

    task automatic test_random;
        int lat, exp_lat;
        logic [15:0] rd, b0a, b0wd, a, d, exp_rd;
        logic er, oth, sw, b0we, we, word, oor;
        int id;
        for (int n = 0; n < 40; n++) begin
            id   = int'($urandom_range(1, 0));
            we   = 1'($urandom_range(1, 0));
            word = 1'($urandom_range(1, 0));
            a    = ($urandom_range(9, 0) == 0) ? 16'($urandom) : 16'($urandom_range(LIMIT + 3, 0));
            d    = 16'($urandom);
            oor  = (int'(a) >= LIMIT) || (word && int'(a) >= LIMIT - 1);
            exp_lat = oor ? 1 : (word ? 3 : 2);
            if (oor || we)  exp_rd = 16'h0;
            else if (word)  exp_rd = {refm[int'(a) + 1], refm[int'(a)]};
            else            exp_rd = {8'h00, refm[int'(a)]};
            do_access(id, we, word, a, d, lat, rd, er, oth, sw, b0we, b0a, b0wd);
            if (we && !oor) begin
                refm[int'(a)] = d[7:0];
                if (word) refm[int'(a) + 1] = d[15:8];
            end
            vectors++;
            if (lat !== exp_lat || rd !== exp_rd || er !== oor || oth !== 1'b0 || sw !== (we && !oor)) begin
                miscompares++;
                $display("FAIL rand[%0d] r%0d we=%b word=%b a=%h: got lat=%0d rdata=%h err=%b other=%b memwe=%b expected %0d %h %b 0 %b",
                         n, id, we, word, a, lat, rd, er, oth, sw, exp_lat, exp_rd, oor, we && !oor);
            end
        end
        for (int i = 0; i < LIMIT; i++) begin
            vectors++;
            if (phys[i] !== refm[i]) begin
                miscompares++;
                $display("FAIL rand_mem[%0d]: got %h expected %h", i, phys[i], refm[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) phys[i] = 8'h00;
        for (int i = 0; i < LIMIT; i++) begin
            refm[i] = 8'($urandom);
            phys[i] = refm[i];
        end
        test_reset;
        test_byte_write;
        test_word_rw;
        test_fairness;
        test_range;
        test_reset_abort;
        test_hold_repeat;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
